// File: rtl/fifo_out_read_operation.sv
// rtl/fifo_out_read_operation.sv - fifo_out read-side controller: head/occupancy tracking, registered read with 1-cycle ack
// Optional macro FIFO_OUT_RD_CNT_EN exposes the registered occupancy as data_count.
module fifo_out_read_operation #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_push,
  input  logic          rd_en,
  input  logic          err_clr,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] dout,
  output logic          rd_ack,
`ifdef FIFO_OUT_RD_CNT_EN
  output logic [AW:0]   data_count,
`endif
  output logic          empty,
  output logic          full,
  output logic          underflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] ERROR = 2'd2;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [1:0]    state;
  logic [AW-1:0] head;
  logic [AW:0]   count;
  logic          accept;
  logic          reject;
  logic          push_ok;

  assign rd_addr = head;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
`ifdef FIFO_OUT_RD_CNT_EN
  assign data_count = count;
`endif

  // ERROR blocks new reads until err_clr; empty is the pre-edge registered value
  assign accept  = (state != ERROR) && rd_en && !empty;
  assign reject  = (state != ERROR) && rd_en && empty;
  assign push_ok = wr_push && !full;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      head      <= '0;
      count     <= '0;
      dout      <= '0;
      rd_ack    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_ack <= accept;
      if (accept) begin
        dout <= rd_data;
        head <= head + 1'b1;
      end

      case ({push_ok, accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE, READ: begin
          if (accept) begin
            state <= READ;
          end else if (reject) begin
            state     <= ERROR;
            underflow <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        ERROR: begin
          if (err_clr) begin
            state     <= IDLE;
            underflow <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_out_read_operation.sv
// tb/tb_fifo_out_read_operation.sv - table-driven self-checking bench for fifo_out_read_operation
module tb_fifo_out_read_operation;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_push;
  logic        rd_en;
  logic        err_clr;
  logic [31:0] rd_data;
  logic [4:0]  rd_addr;
  logic [31:0] dout;
  logic        rd_ack;
  logic        empty;
  logic        full;
  logic        underflow;
`ifdef FIFO_OUT_RD_CNT_EN
  logic [5:0]  data_count;
`endif

  logic [31:0] mem [32];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr];

  fifo_out_read_operation dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_push   (wr_push),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .dout      (dout),
    .rd_ack    (rd_ack),
`ifdef FIFO_OUT_RD_CNT_EN
    .data_count(data_count),
`endif
    .empty     (empty),
    .full      (full),
    .underflow (underflow)
  );

  typedef struct {
    logic        rst_n, push, rd, clr;
    logic [4:0]  e_addr;
    logic [31:0] e_dout;
    logic        e_ack, e_empty, e_full, e_uf;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic p, input logic e, input logic c);
    reset_n = r; wr_push = p; rd_en = e; err_clr = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [4:0] a, input logic [31:0] d,
                         input logic k, input logic em, input logic fu, input logic uf);
    chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(a));
    chk({tag, ".dout"}, dout, d);
    chk({tag, ".rd_ack"}, 32'(rd_ack), 32'(k));
    chk({tag, ".empty"}, 32'(empty), 32'(em));
    chk({tag, ".full"}, 32'(full), 32'(fu));
    chk({tag, ".underflow"}, 32'(underflow), 32'(uf));
  endtask

  task automatic do_reset;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA0 + 32'(i);

    //       rst push rd clr  addr  dout    ack emp full uf
    vt[0]  = '{1, 1, 0, 0, 5'd0, 32'h00, 0, 0, 0, 0};
    vt[1]  = '{1, 1, 0, 0, 5'd0, 32'h00, 0, 0, 0, 0};
    vt[2]  = '{1, 1, 0, 0, 5'd0, 32'h00, 0, 0, 0, 0};
    vt[3]  = '{1, 0, 1, 0, 5'd1, 32'hA0, 1, 0, 0, 0};
    vt[4]  = '{1, 0, 1, 0, 5'd2, 32'hA1, 1, 0, 0, 0};
    vt[5]  = '{1, 0, 1, 0, 5'd3, 32'hA2, 1, 1, 0, 0};
    vt[6]  = '{1, 0, 0, 0, 5'd3, 32'hA2, 0, 1, 0, 0};
    vt[7]  = '{1, 0, 1, 0, 5'd3, 32'hA2, 0, 1, 0, 1};
    vt[8]  = '{1, 0, 1, 0, 5'd3, 32'hA2, 0, 1, 0, 1};
    vt[9]  = '{1, 0, 0, 1, 5'd3, 32'hA2, 0, 1, 0, 0};
    vt[10] = '{1, 1, 0, 0, 5'd3, 32'hA2, 0, 0, 0, 0};
    vt[11] = '{1, 1, 0, 0, 5'd3, 32'hA2, 0, 0, 0, 0};
    vt[12] = '{1, 1, 1, 0, 5'd4, 32'hA3, 1, 0, 0, 0};
    vt[13] = '{1, 0, 1, 0, 5'd5, 32'hA4, 1, 0, 0, 0};
    vt[14] = '{1, 0, 1, 0, 5'd6, 32'hA5, 1, 1, 0, 0};
    vt[15] = '{1, 1, 1, 0, 5'd6, 32'hA5, 0, 0, 0, 1};
    vt[16] = '{1, 0, 0, 1, 5'd6, 32'hA5, 0, 0, 0, 0};
    vt[17] = '{1, 0, 1, 0, 5'd7, 32'hA6, 1, 1, 0, 0};
    vt[18] = '{1, 0, 0, 0, 5'd7, 32'hA6, 0, 1, 0, 0};

    // Reset state
    do_reset();
    chk_all("reset", 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Directed table: pushes, reads, underflow, clear, concurrent push/read
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].rst_n, vt[i].push, vt[i].rd, vt[i].clr);
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].e_addr, vt[i].e_dout, vt[i].e_ack,
              vt[i].e_empty, vt[i].e_full, vt[i].e_uf);
    end

    // Fill to full, overflow push ignored, drain 32 with head wrap
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("fill.full", 32'(full), 32'd1);
`ifdef FIFO_OUT_RD_CNT_EN
    chk("fill.data_count", 32'(data_count), 32'd32);
`endif
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("overpush.full", 32'(full), 32'd1);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk($sformatf("drain%0d.dout", i), dout, 32'hA0 + 32'(i));
      chk($sformatf("drain%0d.rd_ack", i), 32'(rd_ack), 32'd1);
      chk($sformatf("drain%0d.empty", i), 32'(empty), (i == 31) ? 32'd1 : 32'd0);
      if (i == 0) chk("drain0.full", 32'(full), 32'd0);
    end
    chk("wrap.rd_addr", 32'(rd_addr), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wrap.rd_ack_drop", 32'(rd_ack), 32'd0);
    chk("wrap.underflow", 32'(underflow), 32'd0);

    // Reset aborts back-to-back reads with count=5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("abort.pre_dout", dout, 32'hA0);
    tick();
    chk("abort.pre_dout2", dout, 32'hA1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("abort", 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("abort.post_ack", 32'(rd_ack), 32'd0);
    chk("abort.post_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
